// File: rtl/var_clause_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : var_clause_walker                                                |
// | Purpose  : Reads a variable's [start,end] range from var_start_end and      |
// |            streams each clause index downstream; owns the table write port. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 6
`endif

module var_clause_walker #(
    parameter int VAR_BITS = `MAX_VARS_BITS,
    parameter int IDX_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [VAR_BITS-1:0] req_var,
    output logic                req_ready,
    input  logic                abort,
    output logic                out_valid,
    output logic [IDX_BITS-1:0] out_idx,
    input  logic                out_ready,
    output logic                done,
    output logic [IDX_BITS:0]   done_count,
    input  logic                cfg_valid,
    input  logic [VAR_BITS-1:0] cfg_var,
    input  logic [IDX_BITS-1:0] cfg_start,
    input  logic [IDX_BITS-1:0] cfg_end,
    output logic                cfg_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic [VAR_BITS-1:0] mem_var,
    output logic [IDX_BITS-1:0] mem_start_in,
    output logic [IDX_BITS-1:0] mem_end_in,
    input  logic [IDX_BITS-1:0] mem_start_out,
    input  logic [IDX_BITS-1:0] mem_end_out
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_read    = 3'd1;
    localparam logic [2:0] c_st_capture = 3'd2;
    localparam logic [2:0] c_st_stream  = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    localparam logic [IDX_BITS-1:0] c_idx_one = {{(IDX_BITS-1){1'b0}}, 1'b1};
    localparam logic [IDX_BITS:0]   c_cnt_one = {{IDX_BITS{1'b0}}, 1'b1};

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [VAR_BITS-1:0] r_var;
    logic [IDX_BITS-1:0] r_cur;
    logic [IDX_BITS-1:0] r_last;
    logic [IDX_BITS:0]   r_count;

    logic w_accept;
    logic w_handshake;
    logic w_at_last;

    // A simultaneous loader write takes priority over a new walk.
    assign w_accept    = (r_state == c_st_idle) && req_valid && !cfg_valid;
    assign w_handshake = (r_state == c_st_stream) && out_ready;
    assign w_at_last   = (r_cur == r_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_var   <= '0;
            r_cur   <= '0;
            r_last  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_var   <= req_var;
                        r_count <= '0;
                    end
                end
                c_st_capture: begin
                    r_cur   <= mem_start_out;
                    r_last  <= mem_end_out;
                    r_count <= '0;
                end
                c_st_stream: begin
                    // Stopping the increment at last keeps a full-range walk from wrapping.
                    if (w_handshake) begin
                        r_count <= r_count + c_cnt_one;
                        if (!w_at_last) begin
                            r_cur <= r_cur + c_idx_one;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next_state = c_st_read;
                end
            end
            c_st_read: begin
                w_next_state = abort ? c_st_done : c_st_capture;
            end
            c_st_capture: begin
                if (abort || (mem_start_out > mem_end_out)) begin
                    w_next_state = c_st_done;
                end else begin
                    w_next_state = c_st_stream;
                end
            end
            c_st_stream: begin
                if (abort || (w_handshake && w_at_last)) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        cfg_ready    = 1'b0;
        out_valid    = 1'b0;
        out_idx      = '0;
        done         = 1'b0;
        done_count   = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_var      = '0;
        mem_start_in = '0;
        mem_end_in   = '0;
        case (r_state)
            c_st_idle: begin
                req_ready = !cfg_valid;
                cfg_ready = cfg_valid;
                if (cfg_valid) begin
                    mem_write    = 1'b1;
                    mem_var      = cfg_var;
                    mem_start_in = cfg_start;
                    mem_end_in   = cfg_end;
                end
            end
            c_st_read: begin
                mem_read = 1'b1;
                mem_var  = r_var;
            end
            c_st_stream: begin
                out_valid = 1'b1;
                out_idx   = r_cur;
            end
            c_st_done: begin
                done       = 1'b1;
                done_count = r_count;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire
